// File: rtl/core_seq_pkg.sv
// core_seq shared types and decode constants.
// Codes must track the decode stage's ALU_TYPE / REG_WR_SRC tables.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_FETCH = 2'd1,
    ERR_MEM   = 2'd2
  } err_e;

  localparam int unsigned ALU_MC_LO      = 18;
  localparam int unsigned ALU_MC_HI      = 25;
  localparam int unsigned REG_WR_SRC_MEM = 2;

  typedef struct packed {
    logic mc;
    logic load;
    logic store;
    logic reg_wr;
    logic jmp;
    logic br;
  } flags_t;

  function automatic logic is_mc_alu(input logic [31:0] t);
    return (t >= ALU_MC_LO) && (t <= ALU_MC_HI);
  endfunction

endpackage

// File: rtl/core_seq_if.sv
// core_seq handshake bundle: fetch, ALU, memory,
// decode flags and write-back strobes.
interface core_seq_if #(
  parameter int ARGS_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
);

  logic                  i_run;
  logic                  o_fetch_req;
  logic                  i_fetch_ack;
  logic                  o_ir_we;
  logic [ARGS_WIDTH-1:0] i_alu_type;
  logic                  i_jmp_en;
  logic                  i_br_en;
  logic                  i_br_taken;
  logic                  i_mem_wr_en;
  logic                  i_reg_wr_en;
  logic [ARGS_WIDTH-1:0] i_reg_wr_src;
  logic                  i_halt;
  logic                  o_alu_start;
  logic                  i_alu_done;
  logic                  o_mem_req;
  logic                  o_mem_we;
  logic                  i_mem_ack;
  logic                  o_reg_we;
  logic                  o_pc_we;
  logic                  o_pc_sel;
  logic [2:0]            o_state;
  logic                  o_halted;
  logic [1:0]            o_err;
  logic [CNT_WIDTH-1:0]  o_retired;

  modport master (
    input  i_run,
    input  i_fetch_ack,
    input  i_alu_type,
    input  i_jmp_en,
    input  i_br_en,
    input  i_br_taken,
    input  i_mem_wr_en,
    input  i_reg_wr_en,
    input  i_reg_wr_src,
    input  i_halt,
    input  i_alu_done,
    input  i_mem_ack,
    output o_fetch_req,
    output o_ir_we,
    output o_alu_start,
    output o_mem_req,
    output o_mem_we,
    output o_reg_we,
    output o_pc_we,
    output o_pc_sel,
    output o_state,
    output o_halted,
    output o_err,
    output o_retired
  );

  modport slave (
    output i_run,
    output i_fetch_ack,
    output i_alu_type,
    output i_jmp_en,
    output i_br_en,
    output i_br_taken,
    output i_mem_wr_en,
    output i_reg_wr_en,
    output i_reg_wr_src,
    output i_halt,
    output i_alu_done,
    output i_mem_ack,
    input  o_fetch_req,
    input  o_ir_we,
    input  o_alu_start,
    input  o_mem_req,
    input  o_mem_we,
    input  o_reg_we,
    input  o_pc_we,
    input  o_pc_sel,
    input  o_state,
    input  o_halted,
    input  o_err,
    input  o_retired
  );

endinterface

// File: rtl/core_seq_wdt.sv
// Ack watchdog: clearable up-counter, hit at TMO_CYCLES-1.
// Saturates at the limit; the sequencer leaves the wait state on hit.
module core_seq_wdt #(
  parameter int TMO_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam int W =
    (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TMO_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_hit = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && !o_hit) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle instruction sequencer for the L1 core:
// FETCH/DECODE/EXEC/MEM/WB with retire count and ack watchdog.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int ARGS_WIDTH = 8,
  parameter int TMO_CYCLES = 255,
  parameter int CNT_WIDTH  = 32
) (
  input logic        i_clk,
  input logic        i_rst,
  core_seq_if.master bus
);

  state_e               state_q, state_d;
  flags_t               flags_q, flags_d;
  flags_t               dec;
  err_e                 err_q, err_d;
  logic                 taken_q, taken_d;
  logic                 first_q, first_d;
  logic                 halted_q, halted_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic in_wait, wait_ack;
  logic wdt_clr, wdt_inc, wdt_hit;

  logic fetch_req, ir_we, alu_start;
  logic mem_req, mem_we;
  logic reg_we, pc_we, pc_sel;

  always_comb begin
    dec        = '0;
    dec.mc     = is_mc_alu(32'(bus.i_alu_type));
    dec.load   = (32'(bus.i_reg_wr_src) == REG_WR_SRC_MEM);
    dec.store  = bus.i_mem_wr_en;
    dec.reg_wr = bus.i_reg_wr_en;
    dec.jmp    = bus.i_jmp_en;
    dec.br     = bus.i_br_en;
  end

  // Counter idles at zero outside FETCH/MEM, so entry sees a clean count.
  assign in_wait  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_ack = (state_q == S_FETCH) ? bus.i_fetch_ack
                                         : bus.i_mem_ack;
  assign wdt_clr  = !in_wait;
  assign wdt_inc  = in_wait && !wait_ack;

  core_seq_wdt #(
    .TMO_CYCLES(TMO_CYCLES)
  ) u_wdt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(wdt_clr),
    .i_inc(wdt_inc),
    .o_hit(wdt_hit)
  );

  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    err_d     = err_q;
    taken_d   = taken_q;
    first_d   = first_q;
    halted_d  = halted_q;
    retired_d = retired_q;
    fetch_req = 1'b0;
    ir_we     = 1'b0;
    alu_start = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_run) state_d = S_FETCH;
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        ir_we     = bus.i_fetch_ack;
        if (bus.i_fetch_ack) begin
          state_d = S_DECODE;
        end else if (wdt_hit) begin
          state_d = S_ERR;
          err_d   = ERR_FETCH;
        end
      end
      S_DECODE: begin
        flags_d = dec;
        if (bus.i_halt) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          retired_d = retired_q + CNT_WIDTH'(1);
        end else begin
          state_d = S_EXEC;
          first_d = 1'b1;
        end
      end
      S_EXEC: begin
        alu_start = flags_q.mc && first_q;
        first_d   = 1'b0;
        // done may land in the same cycle as the start pulse
        if (!flags_q.mc || bus.i_alu_done) begin
          taken_d = bus.i_br_taken;
          state_d = (flags_q.load || flags_q.store) ? S_MEM
                                                    : S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = flags_q.store;
        if (bus.i_mem_ack) begin
          state_d = S_WB;
        end else if (wdt_hit) begin
          state_d = S_ERR;
          err_d   = ERR_MEM;
        end
      end
      S_WB: begin
        reg_we    = flags_q.reg_wr;
        pc_we     = 1'b1;
        pc_sel    = flags_q.jmp || (flags_q.br && taken_q);
        retired_d = retired_q + CNT_WIDTH'(1);
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      flags_q   <= '0;
      err_q     <= ERR_NONE;
      taken_q   <= 1'b0;
      first_q   <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      err_q     <= err_d;
      taken_q   <= taken_d;
      first_q   <= first_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign bus.o_fetch_req = fetch_req;
  assign bus.o_ir_we     = ir_we;
  assign bus.o_alu_start = alu_start;
  assign bus.o_mem_req   = mem_req;
  assign bus.o_mem_we    = mem_we;
  assign bus.o_reg_we    = reg_we;
  assign bus.o_pc_we     = pc_we;
  assign bus.o_pc_sel    = pc_sel;
  assign bus.o_state     = state_q;
  assign bus.o_halted    = halted_q;
  assign bus.o_err       = err_q;
  assign bus.o_retired   = retired_q;

endmodule

// File: tb/tb_core_seq.sv
// core_seq bench: responder-driven instructions checked
// against a per-instruction latency/strobe model.
module tb_core_seq;

  localparam int AW  = 8;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_seq_if #(.ARGS_WIDTH(AW), .CNT_WIDTH(32)) bus ();

  core_seq #(
    .ARGS_WIDTH(AW),
    .TMO_CYCLES(TMO),
    .CNT_WIDTH(32)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int unsigned retired_m = 0;

  typedef struct {
    int kind;
    logic [AW-1:0] t;
    logic jmp, br, tk, rw, halt;
    logic [AW-1:0] src;
    int fw, mw, n;
  } instr_t;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus.i_alu_type   = AW'($urandom);
    bus.i_jmp_en     = 1'($urandom);
    bus.i_br_en      = 1'($urandom);
    bus.i_br_taken   = 1'($urandom);
    bus.i_mem_wr_en  = 1'($urandom);
    bus.i_reg_wr_en  = 1'($urandom);
    bus.i_reg_wr_src = AW'($urandom);
    bus.i_halt       = 1'($urandom);
  endtask

  task automatic quiet();
    bus.i_fetch_ack  = 1'b0;
    bus.i_mem_ack    = 1'b0;
    bus.i_alu_done   = 1'b0;
    bus.i_alu_type   = '0;
    bus.i_jmp_en     = 1'b0;
    bus.i_br_en      = 1'b0;
    bus.i_br_taken   = 1'b0;
    bus.i_mem_wr_en  = 1'b0;
    bus.i_reg_wr_en  = 1'b0;
    bus.i_reg_wr_src = '0;
    bus.i_halt       = 1'b0;
  endtask

  // kind: 0 = ALU/branch/jump, 1 = load, 2 = store
  function automatic instr_t mk(int kind, int t, bit jmp, bit br,
                                bit tk, bit rw, int fw, int mw,
                                int n, bit halt);
    instr_t r;
    r.kind = kind;
    r.t    = AW'(t);
    r.jmp  = jmp;
    r.br   = br;
    r.tk   = tk;
    r.rw   = (kind == 1) ? 1'b1 : (kind == 2) ? 1'b0 : rw;
    r.src  = (kind == 1) ? AW'(2)
           : ($urandom_range(0, 1) != 0) ? AW'(0) : AW'(3);
    r.halt = halt;
    r.fw   = fw;
    r.mw   = mw;
    r.n    = n;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_run = 1'b0;
    quiet();
    tick();
    tick();
    rst = 1'b0;
    tick();
    retired_m = 0;
    chk("rst_state",   32'(bus.o_state), 0);
    chk("rst_retired", bus.o_retired, 0);
    chk("rst_err",     32'(bus.o_err), 0);
    chk("rst_halted",  32'(bus.o_halted), 0);
    chk("rst_strobes", 32'({bus.o_fetch_req, bus.o_mem_req,
                            bus.o_mem_we, bus.o_ir_we,
                            bus.o_alu_start, bus.o_reg_we,
                            bus.o_pc_we, bus.o_pc_sel}), 0);
  endtask

  task automatic start_run();
    bus.i_run = 1'b1;
    tick();
  endtask

  task automatic run_instr(input instr_t in, input bit exp_err);
    int c = 0, fcnt = 0, mcnt = 0, start_c = 0, starts = 0;
    int irw = 0, mreq = 0, wb_c = 0, dec_c = -10;
    int exp_wb, exec_len;
    bit dec_now = 0, dec_next = 0, started = 0, stop = 0;
    bit mc, ldst, mwe_ok = 1, wr_dec = 0;
    logic rwe = 1'b0, psel = 1'b0;
    mc   = (in.t >= AW'(18)) && (in.t <= AW'(25));
    ldst = (in.kind != 0);
    while (!stop && c < 60) begin
      c++;
      scramble();
      bus.i_fetch_ack = 1'($urandom);
      bus.i_mem_ack   = 1'($urandom);
      bus.i_alu_done  = 1'($urandom);
      dec_now  = dec_next;
      dec_next = 0;
      if (bus.o_fetch_req) begin
        fcnt++;
        bus.i_fetch_ack = (fcnt == in.fw + 1);
        dec_next = bus.i_fetch_ack;
      end
      if (dec_now) begin
        dec_c = c;
        bus.i_alu_type   = in.t;
        bus.i_jmp_en     = in.jmp;
        bus.i_br_en      = in.br;
        bus.i_mem_wr_en  = (in.kind == 2);
        bus.i_reg_wr_en  = in.rw;
        bus.i_reg_wr_src = in.src;
        bus.i_halt       = in.halt;
      end
      if (bus.o_mem_req) begin
        mcnt++;
        bus.i_mem_ack = (mcnt == in.mw + 1);
      end
      if (bus.o_alu_start) begin
        starts++;
        if (!started) start_c = c;
        started = 1;
      end
      if (started && (c - start_c) <= in.n)
        bus.i_alu_done = ((c - start_c) == in.n);
      if (mc ? (started && (c - start_c) == in.n)
             : (c == dec_c + 1))
        bus.i_br_taken = in.tk;
      #1;
      if (bus.o_ir_we) irw++;
      if (bus.o_mem_req) begin
        mreq++;
        if (bus.o_mem_we !== (in.kind == 2)) mwe_ok = 0;
      end
      if (dec_now && (bus.o_pc_we || bus.o_reg_we)) wr_dec = 1;
      if (bus.o_pc_we) begin
        stop = 1;
        wb_c = c;
        rwe  = bus.o_reg_we;
        psel = bus.o_pc_sel;
      end
      if (bus.o_state == 3'd7) stop = 1;
      if (in.halt && dec_now) stop = 1;
      if (!stop) tick();
    end
    if (exp_err) begin
      chk("tmo_mem_cycles", 32'(mreq), 32'(TMO));
      chk("tmo_state", 32'(bus.o_state), 7);
      chk("tmo_err", 32'(bus.o_err), 2);
      chk("tmo_mem_req", 32'(bus.o_mem_req), 0);
      bus.i_mem_ack = 1'b1;
      tick();
      tick();
      chk("tmo_sticky", 32'({bus.o_state, bus.o_err}), 32'({3'd7, 2'd2}));
    end else if (in.halt) begin
      chk("halt_no_write", 32'(wr_dec), 0);
      tick();
      retired_m++;
      chk("halt_state", 32'(bus.o_state), 6);
      chk("halt_flag", 32'(bus.o_halted), 1);
      chk("halt_retired", bus.o_retired, retired_m);
      tick();
      chk("halt_stay", 32'({bus.o_state, bus.o_fetch_req}), 32'({3'd6, 1'b0}));
    end else begin
      exec_len = mc ? in.n + 1 : 1;
      exp_wb = (in.fw + 1) + 1 + exec_len
             + (ldst ? in.mw + 1 : 0) + 1;
      chk("wb_cycle", 32'(wb_c), 32'(exp_wb));
      chk("reg_we", 32'(rwe), 32'(in.rw));
      chk("pc_sel", 32'(psel), 32'(in.jmp | (in.br & in.tk)));
      chk("ir_we_count", 32'(irw), 1);
      chk("mem_req_cycles", 32'(mreq), ldst ? 32'(in.mw + 1) : 0);
      chk("mem_we", 32'(mwe_ok), 1);
      chk("alu_starts", 32'(starts), mc ? 1 : 0);
      tick();
      retired_m++;
      chk("retired", bus.o_retired, retired_m);
      chk("next_fetch", 32'({bus.o_state, bus.o_err}), 32'({3'd1, 2'd0}));
    end
  endtask

  task automatic run_fetch_tmo();
    int n = 0;
    start_run();
    for (int i = 0; i < 20 && bus.o_state != 3'd7; i++) begin
      bus.i_fetch_ack = 1'b0;
      bus.i_mem_ack   = 1'($urandom);
      #1;
      if (bus.o_fetch_req) n++;
      tick();
    end
    chk("ftmo_cycles", 32'(n), 32'(TMO));
    chk("ftmo_state", 32'(bus.o_state), 7);
    chk("ftmo_err", 32'(bus.o_err), 1);
    bus.i_fetch_ack = 1'b1;
    #1;
    chk("ftmo_req_ir", 32'({bus.o_fetch_req, bus.o_ir_we}), 0);
    tick();
    chk("ftmo_sticky", 32'(bus.o_state), 7);
  endtask

  task automatic run_mid_reset();
    start_run();
    run_instr(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 0);
    bus.i_fetch_ack = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_state", 32'(bus.o_state), 0);
    chk("mid_rst_req", 32'(bus.o_fetch_req), 0);
    chk("mid_rst_retired", bus.o_retired, 0);
    rst = 1'b0;
    bus.i_run = 1'b0;
    retired_m = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_run = 1'b0;
    quiet();
    do_reset();
    start_run();
    run_instr(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 0);
    run_instr(mk(1, 0, 0, 0, 0, 1, 0, 3, 0, 0), 0);
    run_instr(mk(0, 22, 0, 0, 0, 1, 0, 0, 5, 0), 0);
    run_instr(mk(0, 5, 0, 1, 1, 0, 0, 0, 0, 0), 0);
    run_instr(mk(0, 5, 0, 1, 0, 0, 0, 0, 0, 0), 0);
    run_instr(mk(2, 0, 0, 0, 0, 0, 1, 2, 0, 0), 0);
    run_instr(mk(0, 0, 1, 0, 0, 1, 2, 0, 0, 0), 0);
    run_instr(mk(0, 25, 0, 0, 0, 1, 0, 0, 0, 0), 0);
    run_instr(mk(0, 18, 0, 0, 0, 1, 0, 0, 1, 0), 0);
    run_instr(mk(0, 17, 0, 0, 0, 1, 0, 0, 3, 0), 0);
    run_instr(mk(0, 26, 0, 0, 0, 1, 0, 0, 3, 0), 0);
    run_instr(mk(0, 1, 0, 0, 0, 1, 3, 0, 0, 0), 0);
    run_instr(mk(2, 1, 0, 0, 0, 0, 0, 3, 0, 0), 0);
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 2);
      int t = ($urandom_range(0, 1) != 0) ? $urandom_range(18, 25)
            : ($urandom_range(0, 1) != 0) ? $urandom_range(0, 17)
                                          : $urandom_range(26, 40);
      run_instr(mk(kind, t, ($urandom_range(0, 3) == 0),
                   1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 6), 0), 0);
    end
    run_instr(mk(1, 0, 0, 0, 0, 1, 0, 99, 0, 0), 1);
    do_reset();
    run_fetch_tmo();
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++)
      run_instr(mk(0, 0, 0, 0, 0, 1, $urandom_range(0, 3), 0, 0, 0), 0);
    run_instr(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1), 0);
    do_reset();
    run_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Multi-cycle sequencer for the L1 core stages. It steps each instruction through FETCH, DECODE, EXEC, optional MEM and WB. It handshakes with the fetch unit, the multi-cycle ALU (MUL/DIV) and the data memory port, and issues the register-file and PC write strobes. It also counts retired instructions and traps stalled memory transactions with a watchdog.

## Interface
Parameters:
- ARGS_WIDTH, 8, width of decoded control codes (alu_type, reg_wr_src).
- TMO_CYCLES, 255, number of cycles without an ack before the watchdog fires; must be ≥1.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- i_clk  in  1  core clock; all logic is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_run  in  1  level; leaves IDLE when high.
- o_fetch_req  out  1  instruction fetch request; held high until ack.
- i_fetch_ack  in  1  fetch data valid this cycle.
- o_ir_we  out  1  instruction register load; equals FETCH & i_fetch_ack.
- i_alu_type  in  ARGS_WIDTH  decoded ALU op; values 18..25 are multi-cycle.
- i_jmp_en  in  1  decoded JAL/JALR.
- i_br_en  in  1  decoded conditional branch.
- i_br_taken  in  1  branch comparison result; valid in the last EXEC cycle.
- i_mem_wr_en  in  1  decoded store.
- i_reg_wr_en  in  1  decoded register write.
- i_reg_wr_src  in  ARGS_WIDTH  decoded write source; 2 = MEM means load.
- i_halt  in  1  decoded EBREAK.
- o_alu_start  out  1  one-cycle start pulse for multi-cycle ALU ops.
- i_alu_done  in  1  multi-cycle ALU result valid.
- o_mem_req  out  1  data memory request; held high until ack.
- o_mem_we  out  1  store qualifier; valid while o_mem_req is high.
- i_mem_ack  in  1  data memory transaction complete.
- o_reg_we  out  1  register-file write strobe, WB only.
- o_pc_we  out  1  PC update strobe, WB only.
- o_pc_sel  out  1  0 = PC+4, 1 = ALU target.
- o_state  out  3  current state encoding, for debug.
- o_halted  out  1  sticky halt.
- o_err  out  2  sticky error: 0 none, 1 fetch timeout, 2 memory timeout.
- o_retired  out  CNT_WIDTH  retired-instruction count; wraps modulo 2^CNT_WIDTH.

## Operation
States and encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.

Transitions:
- IDLE→FETCH when i_run is high.
- FETCH→DECODE on i_fetch_ack.
- DECODE→HALT if i_halt. This counts as a retire, and there is no PC or register write.
- DECODE→EXEC otherwise.
- EXEC→MEM for a load or store; otherwise EXEC→WB.
- MEM→WB on i_mem_ack.
- WB→FETCH.
- HALT and ERR are terminal; only i_rst leaves them.

DECODE latches into internal flags: multi-cycle op, load, store, reg_wr_en, jmp_en, br_en. Decode inputs are ignored in every other state.

EXEC behaviour:
- Single-cycle op: exactly 1 cycle.
- Multi-cycle op: o_alu_start pulses in the first EXEC cycle only. EXEC then waits for i_alu_done, which may arrive in that same first cycle.
- i_br_taken is captured in the EXEC exit cycle.

WB behaviour:
- o_reg_we equals the latched reg_wr_en.
- o_pc_we is 1.
- o_pc_sel = jmp_en | (br_en & captured taken).
- o_retired increments by 1.

Watchdog:
- One counter, cleared on entry to FETCH or MEM and incremented every cycle the ack is low.
- When the counter equals TMO_CYCLES−1 and the ack is still low, the next state is ERR.
- o_err is set to 1 if this happens in FETCH, 2 if in MEM.
- In ERR, o_fetch_req and o_mem_req drop.

## Timing
- Reset: state IDLE; o_retired, o_err, o_halted and the latched flags are 0; all strobes are 0.
- The state register updates on the clock edge. Request and strobe outputs are decoded from the state, except o_ir_we, which is combinational on i_fetch_ack.
- Minimum latency with zero-wait acks:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - MUL/DIV: 4 + N cycles, where done arrives N cycles after the start pulse.
- An ack arriving in the same cycle as the watchdog limit wins: no error is raised.
- An ack outside its owning state is ignored.
- i_rst mid-transaction returns to IDLE on the next edge, clears the counters and flags, and drops the requests in that same edge.

## Structure
- Package core_seq_pkg holds:
  - the state enum;
  - the ALU_TYPE multi-cycle range bounds (18 and 25);
  - REG_WR_SRC_MEM = 2;
  - the o_err codes.
- The ALU_TYPE and REG_WR_SRC values in core_seq_pkg must match the decode stage's codes.
- Sub-module core_seq_wdt: a clearable up-counter with a `hit` output, parameterised by TMO_CYCLES.

## Test plan
- ADDI with fetch ack on the first cycle: o_pc_we and o_reg_we high in cycle 4 after leaving IDLE; o_retired=1.
- LW with mem ack 3 cycles late: o_mem_req high for 4 cycles and o_mem_we=0; WB in cycle 8; o_reg_we=1.
- DIV (type 22) with done 5 cycles after the start pulse: exactly one o_alu_start; WB in cycle 9.
- BEQ taken vs not taken: o_pc_sel 1 vs 0; o_reg_we 0 in both cases.
- Memory ack withheld, TMO_CYCLES=4: state ERR after 4 MEM cycles; o_err=2; o_mem_req low; stays in ERR.
- EBREAK after 3 ADDIs: state HALT; o_halted=1; o_retired=4. Then i_rst: all outputs return to reset values.
